// File: rtl/key_led_pkg.sv
// key_led_pkg: state codes, step-to-code mapping and FSM encoding shared by
// the key hold-time FSM and the downstream LED stage.
package key_led_pkg;

  // LED state codes (bit-exact with the LED stage)
  localparam logic [6:0] IDLE     = 7'b0000001;
  localparam logic [6:0] HALF     = 7'b0000010;
  localparam logic [6:0] ONE      = 7'b0000100;
  localparam logic [6:0] ONE_HALF = 7'b0001000;
  localparam logic [6:0] TWO      = 7'b0010000;
  localparam logic [6:0] TWO_HALF = 7'b0100001;
  localparam logic [6:0] THREE    = 7'b1000001;

  // Highest step index (3 s); the index saturates here
  localparam logic [2:0] STEP_MAX = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEAS,
    S_SHOW
  } fsm_e;

  // Step index 0..6 -> LED code; anything else falls back to IDLE
  function automatic logic [6:0] step_code(input logic [2:0] idx);
    logic [6:0] code;
    case (idx)
      3'd0:    code = IDLE;
      3'd1:    code = HALF;
      3'd2:    code = ONE;
      3'd3:    code = ONE_HALF;
      3'd4:    code = TWO;
      3'd5:    code = TWO_HALF;
      3'd6:    code = THREE;
      default: code = IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser, debounce counter and edge pulses for
// one active-low push key.
//   sys_clk       in  system clock
//   sys_rst       in  asynchronous active-high reset
//   key_in        in  raw key, active-low, asynchronous
//   key_db        out debounced key (1 = released)
//   press_pulse   out 1-cycle pulse the cycle after key_db falls
//   release_pulse out 1-cycle pulse the cycle after key_db rises
module key_debounce #(
  parameter int unsigned DEBOUNCE_CNT = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_db,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CNT - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          db_prev_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          press_q, release_q;

  // Count only while the synchronised key disagrees with the accepted value;
  // any agreement (a bounce back) restarts the count from zero.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      db_q      <= 1'b1;
      db_prev_q <= 1'b1;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_in;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      db_prev_q <= db_q;
      press_q   <= db_prev_q & ~db_q;
      release_q <= ~db_prev_q & db_q;
    end
  end

  assign key_db        = db_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/key_hold_fsm.sv
// key_hold_fsm: measures how long a debounced key is held in STEP_CNT-cycle
// steps (saturating at step 6), drives the LED state code live while held,
// keeps the final code for HOLD_CNT cycles after release, then returns to IDLE.
//   sys_clk  in  system clock
//   sys_rst  in  asynchronous active-high reset
//   key_in   in  raw key, active-low, asynchronous
//   state    out 7-bit LED state code, registered
//   key_busy out high while a debounced press is in progress, registered
module key_hold_fsm
  import key_led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = 1_000_000,
  parameter int unsigned STEP_CNT     = 25_000_000,
  parameter int unsigned HOLD_CNT     = 500_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_in,
  output logic [6:0] state,
  output logic       key_busy
);

  localparam int unsigned SW = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
  localparam int unsigned HW = (HOLD_CNT > 1) ? $clog2(HOLD_CNT) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CNT - 1);

  logic key_db;
  logic press_pulse, release_pulse;

  key_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_in       (key_in),
    .key_db       (key_db),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  fsm_e          fsm_q, fsm_d;
  logic [2:0]    step_idx_q, step_idx_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [6:0]    state_q, state_d;
  logic          busy_q, busy_d;

  logic step_wrap, step_adv, hold_last;

  assign step_wrap = (step_cnt_q == STEP_LAST);
  // Release takes priority over a coincident step wrap
  assign step_adv  = step_wrap && (step_idx_q < STEP_MAX) && !release_pulse;
  assign hold_last = (hold_cnt_q == HOLD_LAST);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fsm_q      <= S_IDLE;
      step_idx_q <= '0;
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
      state_q    <= IDLE;
      busy_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      step_idx_q <= step_idx_d;
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
      busy_q     <= busy_d;
    end
  end

  // Next FSM state and counters
  always_comb begin
    fsm_d      = fsm_q;
    step_idx_d = step_idx_q;
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (fsm_q)
      S_IDLE: begin
        if (press_pulse) begin
          fsm_d      = S_MEAS;
          step_idx_d = '0;
          step_cnt_d = '0;
        end
      end
      S_MEAS: begin
        step_cnt_d = step_wrap ? '0 : step_cnt_q + 1'b1;
        if (release_pulse) begin
          fsm_d      = (step_idx_q == '0) ? S_IDLE : S_SHOW;
          hold_cnt_d = '0;
        end else if (step_adv) begin
          step_idx_d = step_idx_q + 3'd1;
        end
      end
      S_SHOW: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (press_pulse) begin
          fsm_d      = S_MEAS;
          step_idx_d = '0;
          step_cnt_d = '0;
          hold_cnt_d = '0;
        end else if (hold_last) begin
          fsm_d = S_IDLE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs: next LED code and busy flag
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    case (fsm_q)
      S_IDLE: begin
        state_d = IDLE;
        if (press_pulse) busy_d = 1'b1;
      end
      S_MEAS: begin
        if (release_pulse) begin
          busy_d = 1'b0;
        end else if (step_adv) begin
          state_d = step_code(step_idx_q + 3'd1);
        end
      end
      S_SHOW: begin
        if (press_pulse) begin
          state_d = IDLE;
          busy_d  = 1'b1;
        end else if (hold_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign state    = state_q;
  assign key_busy = busy_q;

endmodule

// File: tb/tb_key_hold_fsm.sv
// Scoreboard bench for key_hold_fsm: every stimulus pushes the expected
// {state, key_busy} changes with the cycle they must appear on; a negedge
// monitor pops and compares each observed change.
module tb_key_hold_fsm;

  localparam int D    = 4;
  localparam int STEP = 10;
  localparam int HOLD = 50;
  // key_in drive cycle -> edge where the FSM reacts to the debounced edge
  localparam int LAT  = D + 4;

  localparam logic [6:0] CODE [7] = '{7'b0000001, 7'b0000010, 7'b0000100,
                                      7'b0001000, 7'b0010000, 7'b0100001,
                                      7'b1000001};

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       key_in;
  logic [6:0] state;
  logic       key_busy;

  key_hold_fsm #(
    .DEBOUNCE_CNT(D),
    .STEP_CNT    (STEP),
    .HOLD_CNT    (HOLD)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key_in  (key_in),
    .state   (state),
    .key_busy(key_busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [6:0] code;
    logic       busy;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] prev;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input logic [6:0] code, input logic busy, input int at);
    ev_t e;
    e.code = code;
    e.busy = busy;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Expected events for a press whose FSM reaction edge is p and whose
  // release reaches the FSM hold cycles later.
  task automatic push_meas(input int p, input int hold, input bit expire);
    int n = 0;
    push_ev(CODE[0], 1'b1, p);
    for (int k = 1; k <= 6; k++) begin
      if (STEP * k < hold) begin
        n = k;
        push_ev(CODE[k], 1'b1, p + STEP * k);
      end
    end
    push_ev(CODE[n], 1'b0, p + hold);
    if (n != 0 && expire) push_ev(CODE[0], 1'b0, p + hold + HOLD);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Called at a negedge: press for hold cycles, then release
  task automatic press(input int hold, input bit expire);
    push_meas(cyc + LAT, hold, expire);
    key_in = 1'b0;
    wait_cyc(hold);
    key_in = 1'b1;
  endtask

  task automatic drain(input string tag);
    int budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge sys_clk);
      budget--;
    end
    wait_cyc(15);
    check(tag, exp_q.size(), 0);
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      prev = {CODE[0], 1'b0};
    end else if ({state, key_busy} != prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_change", {state, key_busy}, prev);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_state", state, mon_e.code);
        check("ev_busy", key_busy, mon_e.busy);
        check("ev_cycle", cyc, mon_e.cyc);
      end
      prev = {state, key_busy};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    sys_rst = 1'b1;
    key_in  = 1'b1;
    wait_cyc(3);
    check("reset_state", state, CODE[0]);
    check("reset_busy", key_busy, 1'b0);
    sys_rst = 1'b0;

    // Idle with key released
    wait_cyc(100);
    check("idle_state", state, CODE[0]);
    check("idle_busy", key_busy, 1'b0);

    // Bounce shorter than the debounce window must be ignored
    for (int i = 0; i < 5; i++) begin
      key_in = 1'b0;
      wait_cyc(2);
      key_in = 1'b1;
      wait_cyc(2);
    end
    wait_cyc(20);
    check("bounce_state", state, CODE[0]);
    check("bounce_busy", key_busy, 1'b0);
    check("bounce_q", exp_q.size(), 0);

    // 35-cycle hold: HALF, ONE, ONE_HALF then 50-cycle display
    press(35, 1'b1);
    drain("drain_35");

    // Long hold saturates at THREE
    press(100, 1'b1);
    drain("drain_100");

    // Short press: busy pulse only
    press(6, 1'b1);
    drain("drain_6");

    // Release coinciding with the third step wrap: release wins, ONE stays
    press(30, 1'b1);
    drain("drain_30");

    // Press during the display window restarts measurement
    press(25, 1'b0);
    wait_cyc(15);
    press(35, 1'b1);
    drain("drain_show_press");

    // Press landing exactly on the hold expiry edge wins
    press(15, 1'b0);
    wait_cyc(HOLD);
    press(15, 1'b1);
    drain("drain_expiry_press");

    // Asynchronous reset mid-measurement, key still held afterwards
    push_ev(CODE[0], 1'b1, cyc + LAT);
    push_ev(CODE[1], 1'b1, cyc + LAT + STEP);
    key_in = 1'b0;
    wait_cyc(LAT + STEP + 5);
    check("pre_rst_q", exp_q.size(), 0);
    #2 sys_rst = 1'b1;
    #1;
    check("async_rst_state", state, CODE[0]);
    check("async_rst_busy", key_busy, 1'b0);
    exp_q.delete();
    @(negedge sys_clk);
    wait_cyc(2);
    sys_rst = 1'b0;
    push_meas(cyc + LAT, 25, 1'b1);
    wait_cyc(25);
    key_in = 1'b1;
    drain("drain_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_hold_fsm.md
Name: key_hold_fsm

Overview:
- Upstream state stage for the LED flow controller.
- Debounces one push key and measures its hold time in 0.5 s steps, saturating at 3 s.
- Drives the 7-bit LED state code live while the key is held, keeps the final code for a display window after release, then returns to IDLE by itself.
- The downstream LED stage only reacts to code changes, so this block owns every state transition, including the automatic return to IDLE.

Parameters:
- DEBOUNCE_CNT, 1_000_000: sys_clk cycles the synchronised key must be stable before it is accepted (20 ms at 50 MHz).
- STEP_CNT, 25_000_000: sys_clk cycles per hold step (0.5 s).
- HOLD_CNT, 500_000_000: sys_clk cycles the final code is kept after release (10 s).

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  asynchronous, active-high reset.
- key_in  in  1  raw key, active-low (0 = pressed), asynchronous to sys_clk.
- state  out  7  LED state code, registered.
- key_busy  out  1  high while a debounced press is in progress, registered.

Behaviour:
- State codes (bit-exact, shared with the LED stage):
  - IDLE = 0000001, HALF = 0000010, ONE = 0000100, ONE_HALF = 0001000.
  - TWO = 0010000, TWO_HALF = 0100001, THREE = 1000001.
- Step index 0..6 maps to these codes in that order.
- Reset values: state = IDLE, key_busy = 0, FSM = S_IDLE, all counters 0, debounced key = 1 (released), synchroniser flops = 1.
- Input path:
  - 2-flop synchroniser on key_in.
  - Debounced key flips only after the synchronised value has differed from it for DEBOUNCE_CNT consecutive cycles.
  - Any bounce restarts the debounce count from 0.
- Edges:
  - press_pulse and release_pulse are 1-cycle pulses, asserted the cycle after the debounced key changes.
  - Total latency from a clean key_in edge to the pulse is DEBOUNCE_CNT + 3 cycles.
- FSM states: S_IDLE, S_MEAS, S_SHOW.
- S_IDLE:
  - state = IDLE.
  - On press_pulse: go to S_MEAS, clear step_idx and step_cnt, set key_busy = 1.
- S_MEAS:
  - step_cnt counts 0..STEP_CNT-1 and wraps.
  - On wrap, if step_idx < 6: step_idx increments and state takes the new code on the same edge.
  - At step_idx = 6 the index saturates; state stays THREE and step_cnt keeps wrapping with no effect.
  - On release_pulse: key_busy = 0. If step_idx = 0, go to S_IDLE (state stays IDLE). Otherwise go to S_SHOW and clear hold_cnt; state holds its current code.
  - If release_pulse and a step wrap happen in the same cycle, the release wins and step_idx is not incremented.
- S_SHOW:
  - hold_cnt counts up.
  - At HOLD_CNT-1: state = IDLE and the FSM goes to S_IDLE.
  - On press_pulse: go to S_MEAS, state = IDLE, counters cleared, key_busy = 1. Press wins over a simultaneous hold expiry.
- state changes at most once per cycle and only takes the seven legal codes; the default branch forces IDLE.
- Counter widths:
  - step_cnt: clog2(STEP_CNT).
  - hold_cnt: clog2(HOLD_CNT), which is 29 bits at default.
  - Debounce counter: clog2(DEBOUNCE_CNT).
  - Comparisons are against parameter-1, evaluated at full width.
- Reset mid-operation:
  - Immediate return to the reset values.
  - A key still held when reset is released is seen as a new press after DEBOUNCE_CNT cycles.

Decomposition:
- Package key_led_pkg:
  - The seven state code localparams.
  - A 7-entry step-to-code function.
  - The FSM state encoding.
  - The LED stage imports the same codes.
- Sub-module key_debounce: synchroniser, debounce counter and edge pulses. Ports: sys_clk, sys_rst, key_in, key_db, press_pulse, release_pulse.

Test Plan (DEBOUNCE_CNT=4, STEP_CNT=10, HOLD_CNT=50):
- Reset released with key_in = 1 for 100 cycles -> state = 0000001, key_busy = 0 throughout.
- key_in bounces 0/1 every 2 cycles for 20 cycles, then stays 1 -> no press_pulse; state stays IDLE.
- Clean press held 35 cycles after debounce:
  - state goes HALF, ONE, ONE_HALF at 10-cycle spacing.
  - After release, ONE_HALF is held 50 cycles, then IDLE.
- Press held 100 cycles -> state reaches 1000001 after 6 steps and stays there until release; key_busy falls on release_pulse.
- Press of 6 cycles (under one step) -> key_busy pulses; state never leaves IDLE; FSM returns to S_IDLE.
- Combined case:
  - Press during S_SHOW -> state returns to IDLE on the press_pulse edge and measurement restarts.
  - sys_rst asserted mid-S_MEAS -> state = IDLE and key_busy = 0 immediately (asynchronously).
